// File: rtl/dmg_dma_pkg.sv
// Shared types and constants for the OAM DMA sequencer.
// Holds the state encoding, the fixed bus addresses and the echo-fold helper.
package dmg_dma_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } dma_state_t;

   localparam logic [15:0] OAM_BASE     = 16'hFE00;
   localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
   localparam logic [7:0]  ECHO_LO      = 8'hE0;
   localparam int          LEN_DEFAULT  = 160;

   // Echo RAM (E000-FDFF) mirrors C000-DDFF, so high bytes at or above E0 drop by 0x20.
   function automatic logic [7:0] fold_src_hi(input logic [7:0] hi, input bit en);
      logic [7:0] res;
      res = hi;
      if (en && (hi >= ECHO_LO)) begin
         res = hi - 8'h20;
      end
      return res;
   endfunction

endpackage

// File: rtl/oam_dma_ctrl_if.sv
// Bus bundle between the DMA sequencer (master) and the CPU decode, external bus mux
// and OAM RAM port (slave).
interface oam_dma_ctrl_if;

   // Strobe semantics: nothing here is a valid/ready pair. reg_wr and oam_we are single-cycle
   // qualifiers that only count on clk edges where tick=1; src_data must be valid on any tick
   // while src_rd=1; the addresses and oam_wdata are stable for the whole cycle they qualify.
   logic        reg_wr;
   logic [7:0]  reg_wdata;
   logic [7:0]  reg_rdata;
   logic [15:0] src_addr;
   logic        src_rd;
   logic [7:0]  src_data;
   logic [7:0]  oam_addr;
   logic [7:0]  oam_wdata;
   logic        oam_we;
   logic        dma_active;
   logic        oam_lock;

   modport master (
      input  reg_wr, reg_wdata, src_data,
      output reg_rdata, src_addr, src_rd, oam_addr, oam_wdata, oam_we, dma_active, oam_lock
   );

   modport slave (
      output reg_wr, reg_wdata, src_data,
      input  reg_rdata, src_addr, src_rd, oam_addr, oam_wdata, oam_we, dma_active, oam_lock
   );

endinterface

// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer: a write to FF46 copies LEN bytes from {src_hi,00} to OAM, one byte
// per M-cycle tick, with a one-byte buffer between the source read and the OAM write.
module oam_dma_ctrl
   import dmg_dma_pkg::*;
#(
   parameter int LEN         = LEN_DEFAULT,
   parameter int START_DELAY = 1,
   parameter bit ECHO_FOLD   = 1'b1
) (
   input  logic           clk,
   input  logic           nreset,
   input  logic           tick,
   oam_dma_ctrl_if.master bus,
   output dma_state_t     dbg_state
);

   localparam int               CNT_W    = (START_DELAY < 2) ? 1 : $clog2(START_DELAY + 1);
   localparam logic [7:0]       LAST_IDX = 8'(LEN - 1);
   localparam logic [CNT_W-1:0] DELAY_LD = CNT_W'(START_DELAY);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   dma_state_t       state;
   logic [CNT_W-1:0] dly_cnt;
   logic [7:0]       src_hi_q;
   logic [7:0]       reg_rdata_q;
   logic [7:0]       rd_idx;
   logic [7:0]       wr_idx;
   logic [7:0]       byte_buf;
   logic             wr_pend;
   logic             src_rd_q;
   logic             dma_active_q;

   // A restart leaves dma_active untouched: ownership is kept if we were copying,
   // and it stays low if the write arrived while idle.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state        <= IDLE;
         dly_cnt      <= '0;
         src_hi_q     <= 8'hFF;
         reg_rdata_q  <= 8'hFF;
         rd_idx       <= 8'h00;
         wr_idx       <= 8'h00;
         byte_buf     <= 8'h00;
         wr_pend      <= 1'b0;
         src_rd_q     <= 1'b0;
         dma_active_q <= 1'b0;
      end else if (tick) begin
         if (bus.reg_wr) begin
            reg_rdata_q <= bus.reg_wdata;
            src_hi_q    <= fold_src_hi(bus.reg_wdata, ECHO_FOLD);
            rd_idx      <= 8'h00;
            wr_pend     <= 1'b0;
            src_rd_q    <= 1'b0;
            dly_cnt     <= DELAY_LD;
            state       <= START;
         end else begin
            case (state)
               IDLE: begin
               end
               START: begin
                  dly_cnt <= dly_cnt - CNT_ONE;
                  if (dly_cnt == CNT_ONE) begin
                     rd_idx       <= 8'h00;
                     src_rd_q     <= 1'b1;
                     dma_active_q <= 1'b1;
                     state        <= RUN;
                  end
               end
               RUN: begin
                  byte_buf <= bus.src_data;
                  wr_pend  <= 1'b1;
                  wr_idx   <= rd_idx;
                  if (rd_idx == LAST_IDX) begin
                     src_rd_q <= 1'b0;
                     state    <= DRAIN;
                  end else begin
                     rd_idx <= rd_idx + 8'd1;
                  end
               end
               DRAIN: begin
                  wr_pend      <= 1'b0;
                  dma_active_q <= 1'b0;
                  state        <= IDLE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

   // The write strobe is the only combinational output so that it lands on the same tick
   // that may overwrite byte_buf, and so an async clear of wr_pend kills it at once.
   assign bus.oam_we     = wr_pend & tick;
   assign bus.oam_addr   = wr_idx;
   assign bus.oam_wdata  = byte_buf;
   assign bus.src_addr   = {src_hi_q, rd_idx};
   assign bus.src_rd     = src_rd_q;
   assign bus.reg_rdata  = reg_rdata_q;
   assign bus.dma_active = dma_active_q;
   assign bus.oam_lock   = dma_active_q;
   assign dbg_state      = state;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: random source memory, directed transfer scenarios,
// expectations built from tick-timing rules (read k at T0+D+1+k, write k at T0+D+2+k).
module tb_oam_dma_ctrl;
   import dmg_dma_pkg::*;

   typedef struct {
      int         t;
      logic [7:0] a;
      logic [7:0] d;
   } wr_ev_t;

   logic clk    = 1'b0;
   logic nreset = 1'b0;
   logic tick   = 1'b0;

   dma_state_t a_state;
   dma_state_t b_state;

   int n_chk    = 0;
   int n_err    = 0;
   int tick_cnt = 0;

   logic [7:0]  src_mem   [65536];
   logic [7:0]  oam_mem   [256];
   logic [15:0] a_addr_log[8192];
   logic        a_act_log [8192];
   logic        a_rd_log  [8192];
   logic        b_act_log [8192];

   wr_ev_t a_wr_q[$];
   wr_ev_t b_wr_q[$];
   wr_ev_t exp_q[$];

   always #5 clk = ~clk;

   oam_dma_ctrl_if a_if ();
   oam_dma_ctrl_if b_if ();

   assign a_if.src_data = src_mem[a_if.src_addr];
   assign b_if.src_data = src_mem[b_if.src_addr];

   oam_dma_ctrl #(.LEN(160), .START_DELAY(1), .ECHO_FOLD(1'b1)) u_dut_a (
      .clk      (clk),
      .nreset   (nreset),
      .tick     (tick),
      .bus      (a_if.master),
      .dbg_state(a_state)
   );

   oam_dma_ctrl #(.LEN(1), .START_DELAY(3), .ECHO_FOLD(1'b1)) u_dut_b (
      .clk      (clk),
      .nreset   (nreset),
      .tick     (tick),
      .bus      (b_if.master),
      .dbg_state(b_state)
   );

   // Mid-cycle monitor: values seen here are what the next tick edge acts on.
   always @(negedge clk) begin
      if (tick) begin
         if (a_if.oam_we === 1'b1) begin
            a_wr_q.push_back('{tick_cnt, a_if.oam_addr, a_if.oam_wdata});
            oam_mem[a_if.oam_addr] = a_if.oam_wdata;
         end
         if (b_if.oam_we === 1'b1) begin
            b_wr_q.push_back('{tick_cnt, b_if.oam_addr, b_if.oam_wdata});
         end
         if (tick_cnt < 8192) begin
            a_addr_log[tick_cnt] = a_if.src_addr;
            a_act_log[tick_cnt]  = a_if.dma_active;
            a_rd_log[tick_cnt]   = a_if.src_rd;
            b_act_log[tick_cnt]  = b_if.dma_active;
         end
         tick_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One tick-qualified clock; inputs change 1 time unit after the edge.
   task automatic step(input logic wa, input logic [7:0] da, input logic wb, input logic [7:0] db);
      a_if.reg_wr    = wa;
      a_if.reg_wdata = da;
      b_if.reg_wr    = wb;
      b_if.reg_wdata = db;
      tick           = 1'b1;
      @(posedge clk);
      #1;
      tick        = 1'b0;
      a_if.reg_wr = 1'b0;
      b_if.reg_wr = 1'b0;
   endtask

   task automatic run_until(input int t);
      while (tick_cnt < t) step(1'b0, 8'h00, 1'b0, 8'h00);
   endtask

   task automatic clear_logs();
      a_wr_q.delete();
      b_wr_q.delete();
      exp_q.delete();
      for (int i = 0; i < 256; i++) oam_mem[i] = 'x;
   endtask

   function automatic logic [7:0] ref_hi(input logic [7:0] h);
      return (h >= 8'hE0) ? 8'(h - 8'h20) : h;
   endfunction

   // Expected writes of one transfer; a restart at t_stop keeps writes up to and including t_stop.
   task automatic add_exp(input int t0, input int dly, input int len, input logic [7:0] hi,
                          input int t_stop);
      for (int k = 0; k < len; k++) begin
         int tw;
         tw = t0 + dly + 2 + k;
         if (tw <= t_stop) exp_q.push_back('{tw, 8'(k), src_mem[{ref_hi(hi), 8'(k)}]});
      end
   endtask

   task automatic cmp_writes(input string tag, input wr_ev_t obs[$]);
      int bad;
      bad = 0;
      chk({tag, "_count"}, obs.size(), exp_q.size());
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
         if (obs[i].t != exp_q[i].t || obs[i].a !== exp_q[i].a || obs[i].d !== exp_q[i].d) bad++;
      end
      chk({tag, "_content"}, bad, 0);
   endtask

   function automatic int win_bad(input int sel, input int lo, input int hi, input int w0,
                                  input int w1);
      int   bad;
      logic o;
      logic e;
      bad = 0;
      for (int n = w0; n <= w1; n++) begin
         e = (n >= lo && n <= hi);
         case (sel)
            0:       o = a_act_log[n];
            1:       o = a_rd_log[n];
            default: o = b_act_log[n];
         endcase
         if (o !== e) bad++;
      end
      return bad;
   endfunction

   function automatic int oam_bad(input logic [7:0] hi);
      int bad;
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         if (i < 160 && oam_mem[i] !== src_mem[{ref_hi(hi), 8'(i)}]) bad++;
      end
      return bad;
   endfunction

   initial begin
      int         t0;
      int         bad;
      logic [7:0] hi;
      logic [15:0] s_addr;
      logic [7:0] s_oaddr;
      dma_state_t s_state;

      for (int i = 0; i < 65536; i++) src_mem[i] = 8'($urandom_range(0, 255));
      a_if.reg_wr = 1'b0;  a_if.reg_wdata = 8'h00;
      b_if.reg_wr = 1'b0;  b_if.reg_wdata = 8'h00;
      clear_logs();

      // Reset state
      #12;
      chk("rst_rdata",    32'(a_if.reg_rdata),  32'h00FF);
      chk("rst_src_addr", 32'(a_if.src_addr),   32'hFF00);
      chk("rst_src_rd",   32'(a_if.src_rd),     32'h0);
      chk("rst_oam_we",   32'(a_if.oam_we),     32'h0);
      chk("rst_active",   32'(a_if.dma_active), 32'h0);
      chk("rst_lock",     32'(a_if.oam_lock),   32'h0);
      chk("rst_oam_addr", 32'(a_if.oam_addr),   32'h0);
      chk("rst_state",    32'(a_state),         32'(IDLE));
      @(posedge clk);
      #1;
      nreset = 1'b1;

      // Idle ticks with no write change nothing
      run_until(tick_cnt + 4);
      chk("idle_no_write", a_wr_q.size(),       0);
      chk("idle_src_addr", 32'(a_if.src_addr),  32'hFF00);
      chk("idle_rdata",    32'(a_if.reg_rdata), 32'h00FF);

      // Scenario 1: C1, with a 5-clock tick-low pause and an ignored write mid-RUN
      clear_logs();
      t0 = tick_cnt;
      step(1'b1, 8'hC1, 1'b0, 8'h00);
      run_until(t0 + 80);
      chk("s1_lock_run",   32'(a_if.oam_lock),   32'h1);
      chk("s1_active_run", 32'(a_if.dma_active), 32'h1);
      s_addr  = a_if.src_addr;
      s_oaddr = a_if.oam_addr;
      s_state = a_state;
      bad     = 0;
      for (int c = 0; c < 5; c++) begin
         if (c == 2) begin
            a_if.reg_wr    = 1'b1;
            a_if.reg_wdata = 8'h55;
         end
         @(negedge clk);
         if (a_if.src_addr !== s_addr || a_if.oam_addr !== s_oaddr || a_state !== s_state ||
             a_if.oam_we !== 1'b0) bad++;
         @(posedge clk);
         #1;
         a_if.reg_wr = 1'b0;
      end
      chk("s1_pause_stable", bad, 0);
      chk("s1_pause_rdata",  32'(a_if.reg_rdata), 32'h00C1);
      run_until(t0 + 170);
      add_exp(t0, 1, 160, 8'hC1, 1 << 30);
      cmp_writes("s1_wr", a_wr_q);
      chk("s1_addr_first", 32'(a_addr_log[t0 + 2]),   32'hC100);
      chk("s1_addr_last",  32'(a_addr_log[t0 + 161]), 32'hC19F);
      chk("s1_oam",        oam_bad(8'hC1), 0);
      chk("s1_active_win", win_bad(0, t0 + 2, t0 + 162, t0, t0 + 170), 0);
      chk("s1_src_rd_win", win_bad(1, t0 + 2, t0 + 161, t0, t0 + 170), 0);
      chk("s1_end_state",  32'(a_state), 32'(IDLE));

      // Scenario 2: echo fold E3 -> C3, readback unfolded
      clear_logs();
      t0 = tick_cnt;
      step(1'b1, 8'hE3, 1'b0, 8'h00);
      chk("s2_rdata", 32'(a_if.reg_rdata), 32'h00E3);
      run_until(t0 + 170);
      add_exp(t0, 1, 160, 8'hE3, 1 << 30);
      cmp_writes("s2_wr", a_wr_q);
      chk("s2_addr_first", 32'(a_addr_log[t0 + 2]), 32'hC300);
      chk("s2_oam",        oam_bad(8'hE3), 0);

      // Scenario 3: restart with D0 at T50 during RUN
      clear_logs();
      hi = 8'($urandom_range(0, 255));
      t0 = tick_cnt;
      step(1'b1, hi, 1'b0, 8'h00);
      run_until(t0 + 50);
      step(1'b1, 8'hD0, 1'b0, 8'h00);
      chk("s3_active_start", 32'(a_if.dma_active), 32'h1);
      chk("s3_state_start",  32'(a_state),         32'(START));
      run_until(t0 + 50 + 170);
      add_exp(t0, 1, 160, hi, t0 + 50);
      add_exp(t0 + 50, 1, 160, 8'hD0, 1 << 30);
      cmp_writes("s3_wr", a_wr_q);
      bad = 0;
      foreach (a_wr_q[i]) if (a_wr_q[i].t == t0 + 50 && a_wr_q[i].a == 8'd47) bad++;
      chk("s3_byte47_at_t50", bad, 1);
      chk("s3_addr_new",   32'(a_addr_log[t0 + 52]), 32'hD000);
      chk("s3_active_win", win_bad(0, t0 + 2, t0 + 50 + 162, t0, t0 + 220), 0);

      // Scenario 4: async reset mid-RUN, then a fresh transfer
      clear_logs();
      hi = 8'($urandom_range(0, 255));
      t0 = tick_cnt;
      step(1'b1, hi, 1'b0, 8'h00);
      run_until(t0 + 30);
      tick = 1'b1;
      #1;
      chk("s4_pre_rst_we", 32'(a_if.oam_we), 32'h1);
      #1;
      nreset = 1'b0;
      #1;
      chk("s4_rst_we",       32'(a_if.oam_we),     32'h0);
      chk("s4_rst_rdata",    32'(a_if.reg_rdata),  32'h00FF);
      chk("s4_rst_src_addr", 32'(a_if.src_addr),   32'hFF00);
      chk("s4_rst_active",   32'(a_if.dma_active), 32'h0);
      chk("s4_rst_src_rd",   32'(a_if.src_rd),     32'h0);
      chk("s4_rst_oam_addr", 32'(a_if.oam_addr),   32'h0);
      @(posedge clk);
      #1;
      tick   = 1'b0;
      nreset = 1'b1;
      clear_logs();
      run_until(tick_cnt + 10);
      chk("s4_post_no_write", a_wr_q.size(), 0);
      chk("s4_post_active",   32'(a_if.dma_active), 32'h0);
      hi = 8'($urandom_range(0, 255));
      t0 = tick_cnt;
      step(1'b1, hi, 1'b0, 8'h00);
      run_until(t0 + 170);
      add_exp(t0, 1, 160, hi, 1 << 30);
      cmp_writes("s4_wr", a_wr_q);
      chk("s4_oam", oam_bad(hi), 0);

      // Scenario 5: LEN=1, START_DELAY=3 instance
      clear_logs();
      hi = 8'($urandom_range(0, 255));
      t0 = tick_cnt;
      step(1'b0, 8'h00, 1'b1, hi);
      run_until(t0 + 10);
      add_exp(t0, 3, 1, hi, 1 << 30);
      cmp_writes("s5_wr", b_wr_q);
      chk("s5_active_win", win_bad(2, t0 + 4, t0 + 5, t0, t0 + 10), 0);
      chk("s5_end_state",  32'(b_state), 32'(IDLE));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
